// File: rtl/keypad_pkg.sv
// Shared helpers for the keypad scanner: key-code width and code composition.
package keypad_pkg;

  // Width of a key code for a ROWS x COLS matrix.
  function automatic int key_w(input int rows, input int cols);
    return (rows * cols <= 2) ? 1 : $clog2(rows * cols);
  endfunction

  // Key code of a matrix position, row-major.
  function automatic int key_code(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event handshake between the scanner (master) and the game fsm (slave).
interface keypad_scanner_if #(
  parameter int KEY_W = 4
) ();
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             key_ready;

  modport master (output key, output key_valid, input key_ready);
  modport slave  (input key, input key_valid, output key_ready);
endinterface

// File: rtl/key_fifo.sv
// First-word-fall-through event FIFO; a push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next state; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage write; contents need no reset since head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// ROWS x COLS matrix keypad scanner: row drive, column sampling, per-frame
// lowest-code priority, frame-level debounce and a key event FIFO.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COLS-1:0]     columna_i,
  output logic [ROWS-1:0]     fila_o,
  output logic                keypad_pressed_o,
  output logic                overflow_o,
  keypad_scanner_if.master    evt
);
  localparam int KEY_W = key_w(ROWS, COLS);
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0]  sync1_q, sync2_q;
  logic [DW-1:0]    div_q, div_d;
  logic [RW-1:0]    row_q, row_d;
  logic             div_last, frame_end;

  // Partial candidate of the frame in progress (rows already sampled).
  logic             acc_hit_q, acc_hit_d;
  logic [KEY_W-1:0] acc_code_q, acc_code_d;
  // Previous frame candidate and debounce counter.
  logic             prev_hit_q, prev_hit_d;
  logic [KEY_W-1:0] prev_code_q, prev_code_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;
  // Committed (debounced) key state.
  logic             stable_hit_q, stable_hit_d;
  logic [KEY_W-1:0] stable_code_q, stable_code_d;
  logic             overflow_q, overflow_d;

  logic             row_hit, frame_hit, same, commit, push, pop, full, empty;
  logic [KEY_W-1:0] row_code, frame_code, head;

  assign div_last  = (div_q == DW'(SCAN_DIV - 1));
  assign frame_end = div_last && (row_q == RW'(ROWS - 1));
  assign fila_o    = ~(ROWS'(1) << row_q);

  // Lowest active column of the row currently being sampled.
  always_comb begin
    row_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!sync2_q[c]) row_code = KEY_W'(key_code(int'(row_q), c, COLS));
    end
  end

  // Rows are scanned in ascending order, so the first hit in a frame is the lowest code.
  always_comb begin
    row_hit    = ~&sync2_q;
    frame_hit  = acc_hit_q | row_hit;
    frame_code = acc_hit_q ? acc_code_q : row_code;
    same       = (frame_hit == prev_hit_q) && (!frame_hit || frame_code == prev_code_q);
    cnt_nxt    = same ? ((cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1) : CW'(1);
    commit     = frame_end && (cnt_nxt == CW'(DEBOUNCE)) &&
                 ((frame_hit != stable_hit_q) || (frame_hit && frame_code != stable_code_q));
    push       = commit && frame_hit;
  end

  // Scan, frame accumulation and debounce next state.
  always_comb begin
    div_d         = div_last ? '0 : div_q + 1'b1;
    row_d         = row_q;
    acc_hit_d     = acc_hit_q;
    acc_code_d    = acc_code_q;
    prev_hit_d    = prev_hit_q;
    prev_code_d   = prev_code_q;
    cnt_d         = cnt_q;
    stable_hit_d  = stable_hit_q;
    stable_code_d = stable_code_q;
    if (div_last) begin
      row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      if (frame_end) begin
        acc_hit_d   = 1'b0;
        prev_hit_d  = frame_hit;
        prev_code_d = frame_code;
        cnt_d       = cnt_nxt;
        if (commit) begin
          stable_hit_d  = frame_hit;
          stable_code_d = frame_code;
        end
      end else if (!acc_hit_q && row_hit) begin
        acc_hit_d  = 1'b1;
        acc_code_d = row_code;
      end
    end
  end

  assign pop        = !empty && evt.key_ready;
  assign overflow_d = overflow_q | (push && full && !pop);

  // State registers; the column synchroniser idles high (no key).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      div_q         <= '0;
      row_q         <= '0;
      acc_hit_q     <= 1'b0;
      acc_code_q    <= '0;
      prev_hit_q    <= 1'b0;
      prev_code_q   <= '0;
      cnt_q         <= '0;
      stable_hit_q  <= 1'b0;
      stable_code_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      sync1_q       <= columna_i;
      sync2_q       <= sync1_q;
      div_q         <= div_d;
      row_q         <= row_d;
      acc_hit_q     <= acc_hit_d;
      acc_code_q    <= acc_code_d;
      prev_hit_q    <= prev_hit_d;
      prev_code_q   <= prev_code_d;
      cnt_q         <= cnt_d;
      stable_hit_q  <= stable_hit_d;
      stable_code_q <= stable_code_d;
      overflow_q    <= overflow_d;
    end
  end

  key_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (frame_code),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head)
  );

  assign evt.key          = head;
  assign evt.key_valid    = !empty;
  assign keypad_pressed_o = stable_hit_q;
  assign overflow_o       = overflow_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives columna from fila, a
// scoreboard queue holds expected event codes, a monitor pops on handshakes.
module tb_keypad_scanner;
  logic        clk;
  logic        rst;
  logic [3:0]  columna;
  logic [3:0]  fila;
  logic        pressed;
  logic        overflow;
  logic [15:0] held;
  int          checks;
  int          failures;
  int          exp_q[$];
  int          exp_code;

  keypad_scanner_if #(.KEY_W(4)) kif ();

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .columna_i        (columna),
    .fila_o           (fila),
    .keypad_pressed_o (pressed),
    .overflow_o       (overflow),
    .evt              (kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad model: a held key pulls its column low while its row is driven.
  always_comb begin
    columna = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !fila[r]) columna[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Consumer side: every accepted event must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && kif.key_valid && kif.key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got key %0d expected none", kif.key);
      end else begin
        exp_code = exp_q.pop_front();
        if (32'(kif.key) != exp_code) begin
          failures++;
          $display("FAIL event_order: got key %0d expected %0d", kif.key, exp_code);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next frame boundary (row 3 -> row 0 wrap).
  task automatic wait_frame();
    logic [3:0] last;
    bit         done;
    last = fila;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (fila == 4'b1110 && last != 4'b1110) done = 1'b1;
      last = fila;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got no row wrap expected one within 40 cycles");
    end
  endtask

  task automatic frames(input int n);
    repeat (n) wait_frame();
  endtask

  task automatic hold_key(input int code);
    held = '0;
    held[code] = 1'b1;
  endtask

  typedef struct {
    int code;
    int hold;
    bit exp_evt;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{code: 0,  hold: 3, exp_evt: 1'b1};
    tbl[1] = '{code: 15, hold: 4, exp_evt: 1'b1};
    tbl[2] = '{code: 7,  hold: 2, exp_evt: 1'b0};
    tbl[3] = '{code: 12, hold: 1, exp_evt: 1'b0};
    tbl[4] = '{code: 3,  hold: 3, exp_evt: 1'b1};

    checks = 0;
    failures = 0;
    held = '0;
    kif.key_ready = 1'b1;

    // Reset values and first row advance.
    rst = 1'b1;
    step();
    step();
    chk("reset_fila", 32'(fila), 32'b1110);
    chk("reset_valid", 32'(kif.key_valid), 0);
    chk("reset_key", 32'(kif.key), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_pressed", 32'(pressed), 0);
    rst = 1'b0;
    repeat (7) step();
    chk("row0_dwell", 32'(fila), 32'b1110);
    step();
    chk("row1_after_8", 32'(fila), 32'b1101);

    // Single press of key 9, exact event timing, release with no extra event.
    wait_frame();
    exp_q.push_back(9);
    hold_key(9);
    frames(2);
    chk("single_early", 32'(kif.key_valid), 0);
    wait_frame();
    chk("single_valid", 32'(kif.key_valid), 1);
    chk("single_key", 32'(kif.key), 9);
    chk("single_pressed", 32'(pressed), 1);
    frames(2);
    held = '0;
    frames(2);
    chk("release_still_held", 32'(pressed), 1);
    wait_frame();
    chk("release_pressed", 32'(pressed), 0);

    // Bounce: key 9 on alternate frames never commits.
    for (int f = 0; f < 10; f++) begin
      if (f % 2 == 0) hold_key(9);
      else held = '0;
      wait_frame();
      chk("bounce_pressed", 32'(pressed), 0);
    end
    held = '0;
    frames(3);

    // Table of single presses of varying length.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].exp_evt) exp_q.push_back(tbl[i].code);
      hold_key(tbl[i].code);
      frames(tbl[i].hold);
      chk("tbl_pressed", 32'(pressed), 32'(tbl[i].exp_evt));
      held = '0;
      frames(3);
      chk("tbl_released", 32'(pressed), 0);
    end

    // Two keys: lowest code wins, then the other commits after release of the first.
    exp_q.push_back(5);
    held = '0;
    held[5] = 1'b1;
    held[10] = 1'b1;
    frames(3);
    chk("two_valid", 32'(kif.key_valid), 1);
    chk("two_key", 32'(kif.key), 5);
    frames(2);
    exp_q.push_back(10);
    hold_key(10);
    frames(2);
    chk("two_early", 32'(kif.key_valid), 0);
    wait_frame();
    chk("two_second_valid", 32'(kif.key_valid), 1);
    chk("two_second_key", 32'(kif.key), 10);
    held = '0;
    frames(3);
    chk("two_released", 32'(pressed), 0);

    // Backpressure and overflow: 6 is dropped on a full FIFO.
    kif.key_ready = 1'b0;
    foreach (tbl[i]) begin end
    for (int i = 0; i < 5; i++) begin
      int code;
      code = (i < 4) ? i + 1 : 6;
      if (i < 4) exp_q.push_back(code);
      hold_key(code);
      frames(3);
      held = '0;
      frames(3);
      if (i == 3) chk("ovf_before", 32'(overflow), 0);
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_head", 32'(kif.key), 1);
    kif.key_ready = 1'b1;
    repeat (3) step();
    chk("drain_last_valid", 32'(kif.key_valid), 1);
    chk("drain_last_key", 32'(kif.key), 4);
    step();
    chk("drain_empty", 32'(kif.key_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset mid-operation with two events queued and key 9 held.
    kif.key_ready = 1'b0;
    hold_key(1);
    frames(3);
    held = '0;
    frames(3);
    hold_key(9);
    frames(3);
    chk("pre_rst_valid", 32'(kif.key_valid), 1);
    chk("pre_rst_pressed", 32'(pressed), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(kif.key_valid), 0);
    chk("mid_rst_pressed", 32'(pressed), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_fila", 32'(fila), 32'b1110);
    rst = 1'b0;
    exp_q.push_back(9);
    kif.key_ready = 1'b1;
    frames(2);
    chk("rerun_early", 32'(kif.key_valid), 0);
    wait_frame();
    chk("rerun_valid", 32'(kif.key_valid), 1);
    chk("rerun_key", 32'(kif.key), 9);
    held = '0;
    frames(3);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the game board. It generalises the fixed 4x4 keypad to ROWS x COLS and adds per-key debounce, lowest-code priority on multiple presses, and a first-word-fall-through event FIFO with a valid/ready handshake. It sits between the keypad pins (`fila`/`columna`) and the game `fsm`, and replaces the fixed keypad module in `top`.

## Interface
- ROWS, 4, number of matrix rows driven (>= 2)
- COLS, 4, number of matrix columns sensed (>= 2)
- SCAN_DIV, 50000, clock cycles each row stays driven (>= 4)
- DEBOUNCE, 4, consecutive identical frames needed to commit a key state (>= 1)
- FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)
- KEY_W, derived clog2(ROWS*COLS), key code width; not user-overridable
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- columna  in  COLS  column sense, active-low (pulled up externally), asynchronous
- fila  out  ROWS  row drive, active-low, one-hot-zero
- key  out  KEY_W  FIFO head key code (row*COLS + col); valid only while key_valid = 1
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts head; pop when key_valid && key_ready
- keypad_pressed  out  1  a debounced key is currently held
- overflow  out  1  sticky; set when an event is dropped on a full FIFO

## Operation
- Synchroniser: columna passes through 2 flops before use.
- Row scan: the divider counts 0..SCAN_DIV-1. The row index advances on the divider's last cycle and wraps ROWS-1 -> 0. fila = ~(1 << row).
- Sampling: synchronised columns are sampled on the divider's last cycle of each row. This gives SCAN_DIV-3 settle cycles.
- Frame = ROWS dwells. Within a frame, the lowest code with a sampled 0 is the frame candidate. If no column reads 0, the candidate is NONE (internal flag, not a code).
- Debounce: compare the frame candidate to the previous frame's candidate. Same → counter increments, saturating at DEBOUNCE. Different → counter reloads to 1.
- Commit: when counter == DEBOUNCE and candidate != stable state, stable state takes the candidate.
  - Commit to a key (from NONE or from a different key) → push that code as an event.
  - Commit to NONE → no event.
- keypad_pressed = stable state != NONE.
- FIFO:
  - Push with FIFO full and no simultaneous pop → drop the event, set overflow.
  - Push and pop in the same cycle → both take effect, including when full.
  - FIFO order is strictly arrival order.
- overflow clears only on rst.
- rst (at any time, including mid-frame or with FIFO non-empty): row=0, divider=0, debounce counter=0, candidate=stable=NONE, FIFO emptied.

## Timing
- Reset values: fila = {ROWS-1{1},0} (row 0 driven), key = 0, key_valid = 0, keypad_pressed = 0, overflow = 0.
- Frame length is ROWS*SCAN_DIV cycles. The frame boundary is the last cycle of row ROWS-1.
- Commit is evaluated on the frame-boundary cycle T.
  - Stable state and keypad_pressed update at T+1.
  - A pushed event makes key_valid = 1 and key = code at T+1.
- Minimum press-to-event latency: DEBOUNCE frames after the first frame in which the key is sampled, plus 1 cycle.
- Pop: an accepted handshake at cycle P updates the head at P+1. key_valid drops at P+1 if the FIFO is then empty.
- key is stable while key_valid && !key_ready.
- A release followed by a re-press of the same key produces a new event. Holding a key produces exactly one event (no auto-repeat).

## Structure
- Package keypad_pkg: clog2-based KEY_W function, and code composition helper (row*COLS+col).
- Sub-module key_fifo: FIFO_DEPTH x KEY_W, FWFT. Ports: push, push_data, pop, full, empty, head.
- Everything else lives in keypad_scanner: synchroniser, divider, row counter, frame priority encoder, debounce FSM, overflow flag.

## Test plan
Common configuration: ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4 (frame = 32 cycles).
- Reset: rst high 2 cycles → fila=4'b1110, key_valid=0, overflow=0. fila reaches 4'b1101 8 cycles after rst release.
- Single press: columna[1]=0 whenever fila[2]=0, held for 5 frames →
  - one event key=9 appears 1 cycle after the 3rd full frame boundary;
  - keypad_pressed=1;
  - after release, keypad_pressed=0 three frames later with no extra event.
- Bounce: key 9 present on alternate frames for 10 frames → no event, keypad_pressed stays 0.
- Two keys: codes 5 and 10 held together → single event key=5. Then release 5 with 10 still held → event key=10 after 3 frames.
- Backpressure and overflow: key_ready=0, five distinct debounced presses (1,2,3,4,6) →
  - FIFO holds 1,2,3,4; overflow=1; 6 is dropped;
  - with key_ready=1, pops return 1,2,3,4 on consecutive cycles, then key_valid=0.
- Reset mid-operation: assert rst with 2 events queued and key 9 held → key_valid=0 and keypad_pressed=0 next cycle. Re-debounce produces event 9 three frames after release of rst.
